// File: rtl/bcd_conv_sequencer.sv
// Multi-digit BCD-to-binary conversion controller: one packed BCD word in,
// digits folded MSB-first with acc = acc*10 + digit, binary result or error out.
module bcd_conv_sequencer #(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14,
    parameter int IDX_W  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BIN_W-1:0]      bin_out,
    output logic                  err,
    output logic                  busy,
    output logic [IDX_W-1:0]      digit_idx
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state_r;
    logic [4*DIGITS-1:0]   word_r;
    logic [BIN_W-1:0]      acc_r;

    logic [4*DIGITS-1:0]   shifted_s;
    logic [3:0]            digit_s;
    logic                  digit_bad_s;
    logic                  last_digit_s;
    logic [BIN_W-1:0]      acc_next_s;

    // One accumulate step; the x10 is built from shifts in a widened datapath.
    function automatic logic [BIN_W-1:0] mul10_add(input logic [BIN_W-1:0] acc,
                                                   input logic [3:0]       digit);
        logic [BIN_W+3:0] wide;
        wide = ({4'b0000, acc} << 3) + ({4'b0000, acc} << 1)
             + {{BIN_W{1'b0}}, digit};
        return BIN_W'(wide);
    endfunction

    // Select the current digit (index 0 is the most significant) and precompute the step.
    always_comb begin
        shifted_s    = word_r << {digit_idx, 2'b00};
        digit_s      = 4'(shifted_s >> (4*DIGITS-4));
        digit_bad_s  = (digit_s > 4'd9);
        last_digit_s = (digit_idx == IDX_W'(DIGITS-1));
        acc_next_s   = mul10_add(acc_r, digit_s);
    end

    // Sequencer state, datapath registers and all registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r   <= IDLE;
            word_r    <= {(4*DIGITS){1'b0}};
            acc_r     <= {BIN_W{1'b0}};
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            bin_out   <= {BIN_W{1'b0}};
            err       <= 1'b0;
            busy      <= 1'b0;
            digit_idx <= {IDX_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        state_r   <= CONV;
                        word_r    <= bcd_in;
                        acc_r     <= {BIN_W{1'b0}};
                        in_ready  <= 1'b0;
                        busy      <= 1'b1;
                        digit_idx <= {IDX_W{1'b0}};
                    end else begin
                        state_r   <= IDLE;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        digit_idx <= {IDX_W{1'b0}};
                    end
                end
                CONV: begin
                    if (digit_bad_s) begin
                        // A bad digit aborts the word; remaining digits are never looked at.
                        state_r   <= DONE;
                        acc_r     <= {BIN_W{1'b0}};
                        bin_out   <= {BIN_W{1'b0}};
                        err       <= 1'b1;
                        out_valid <= 1'b1;
                        digit_idx <= {IDX_W{1'b0}};
                    end else if (last_digit_s) begin
                        state_r   <= DONE;
                        acc_r     <= acc_next_s;
                        bin_out   <= acc_next_s;
                        err       <= 1'b0;
                        out_valid <= 1'b1;
                        digit_idx <= {IDX_W{1'b0}};
                    end else begin
                        state_r   <= CONV;
                        acc_r     <= acc_next_s;
                        digit_idx <= digit_idx + IDX_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_r   <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end else begin
                        state_r   <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    digit_idx <= {IDX_W{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_conv_sequencer.sv
// Randomized and directed bench for bcd_conv_sequencer, checked against a
// plain-arithmetic decimal model of each word.
module tb_bcd_conv_sequencer;

    localparam int DIGITS = 4;
    localparam int BIN_W  = 14;
    localparam int IDX_W  = 2;

    logic               clk;
    logic               reset;
    logic               in_valid;
    logic               in_ready;
    logic [15:0]        bcd_in;
    logic               out_valid;
    logic               out_ready;
    logic [BIN_W-1:0]   bin_out;
    logic               err;
    logic               busy;
    logic [IDX_W-1:0]   digit_idx;

    int pass_cnt  = 0;
    int check_cnt = 0;

    bcd_conv_sequencer #(.DIGITS(DIGITS), .BIN_W(BIN_W), .IDX_W(IDX_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bcd_in    (bcd_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bin_out   (bin_out),
        .err       (err),
        .busy      (busy),
        .digit_idx (digit_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Decimal interpretation of a word: value, error flag, cycles until result.
    function automatic void model(input logic [15:0] w, output int bin, output int e, output int lat);
        int d;
        bin = 0; e = 0; lat = DIGITS;
        for (int i = 0; i < DIGITS; i++) begin
            d = int'((w >> (4*(DIGITS-1-i))) & 16'hF);
            if (d > 9) begin
                e = 1; bin = 0; lat = i + 1;
                break;
            end
            bin = bin * 10 + d;
        end
    endfunction

    task automatic check_reset_state(input string tag);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_bin_out"},   bin_out,   0);
        check({tag, "_err"},       err,       0);
        check({tag, "_in_ready"},  in_ready,  1);
        check({tag, "_busy"},      busy,      0);
        check({tag, "_digit_idx"}, digit_idx, 0);
    endtask

    task automatic run_word(input logic [15:0] w, input int hold);
        int eb, ee, el, n;
        model(w, eb, ee, el);
        check("in_ready_idle", in_ready, 1);
        in_valid = 1'b1; bcd_in = w;
        step();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            check("busy_conv", busy, 1);
            check("in_ready_conv", in_ready, 0);
            check("digit_idx_conv", digit_idx, n);
            in_valid  = 1'($urandom_range(0, 1));
            bcd_in    = 16'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            step();
            n++;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        check("latency", n, el);
        check("bin_out", bin_out, eb);
        check("err", err, ee);
        check("busy_done", busy, 1);
        check("digit_idx_done", digit_idx, 0);
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1; bcd_in = 16'h1111;
            step();
            check("hold_out_valid", out_valid, 1);
            check("hold_bin_out", bin_out, eb);
            check("hold_err", err, ee);
            check("hold_in_ready", in_ready, 0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("post_out_valid", out_valid, 0);
        check("post_in_ready", in_ready, 1);
        check("post_busy", busy, 0);
        check("post_bin_out", bin_out, eb);
        check("post_err", err, ee);
    endtask

    initial begin
        logic [15:0] w;
        int n;
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; bcd_in = 16'h0000;
        step(); step();
        check_reset_state("reset");
        reset = 1'b1;
        step();

        run_word(16'h1234, 0);
        run_word(16'h9999, 0);
        run_word(16'h0000, 0);
        run_word(16'h12A4, 1);
        run_word(16'hF000, 0);
        run_word(16'h0507, 5);

        // Reset in the middle of a conversion, at digit index 2.
        in_valid = 1'b1; bcd_in = 16'h9876;
        step();
        in_valid = 1'b0;
        step(); step();
        check("mid_conv_idx", digit_idx, 2);
        reset = 1'b0;
        step();
        reset = 1'b1;
        check_reset_state("rst_conv");
        step();
        check_reset_state("rst_conv_hold");
        run_word(16'h0042, 0);

        for (int i = 0; i < 30; i++) begin
            w = 16'h0000;
            for (int d = 0; d < DIGITS; d++) begin
                if ($urandom_range(0, 9) == 0) w = w | (16'($urandom_range(10, 15)) << (4*d));
                else                           w = w | (16'($urandom_range(0, 9)) << (4*d));
            end
            run_word(w, int'($urandom_range(0, 3)));
        end

        // Reset wins over a simultaneous output handshake.
        in_valid = 1'b1; bcd_in = 16'h0815;
        step();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
        check("pre_rst_done_valid", out_valid, 1);
        check("pre_rst_done_bin", bin_out, 815);
        reset = 1'b0; out_ready = 1'b1;
        step();
        reset = 1'b1; out_ready = 1'b0;
        check_reset_state("rst_done");
        run_word(16'h3141, 2);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/bcd_conv_sequencer.md
Name: bcd_conv_sequencer

Overview:
Multi-digit BCD-to-binary conversion controller.
- Accepts one packed BCD word per transaction through a valid/ready handshake.
- Steps through the digits MSB-first, one digit per cycle, using an accumulate step acc = acc*10 + digit.
- Detects invalid digits (values 10 to 15) and returns the binary result, or an error, through a valid/ready output handshake.
- Sits between the operand source and the binary consumers. Sequences the shared per-digit convert step.

Parameters:
DIGITS, 4, number of BCD digits per input word (must be 2 or more).
BIN_W, 14, binary result width. Must be at least ceil(log2(10^DIGITS)); 14 covers 9999.
IDX_W, 2, digit index width, equal to clog2(DIGITS).

Ports:
clk  input  1  clock; all logic on its rising edge.
reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
in_valid  input  1  bcd_in holds a word to convert.
in_ready  output  1  block can accept a word.
bcd_in  input  4*DIGITS  packed BCD; bits [4*DIGITS-1 -: 4] are the most significant digit.
out_valid  output  1  bin_out/err hold a finished result.
out_ready  input  1  consumer takes the result.
bin_out  output  BIN_W  binary result.
err  output  1  the word contained a digit greater than 9.
busy  output  1  high in every state except IDLE.
digit_idx  output  IDX_W  index of the digit being processed in CONV (0 = MSB). 0 in all other states.

Behaviour:
- Reset (reset==0 at a clock edge):
  - state = IDLE, in_ready = 1, out_valid = 0, bin_out = 0, err = 0, busy = 0, digit_idx = 0.
  - Internal accumulator and the captured word are cleared.
  - Reset has priority over all other inputs, including in the middle of CONV or DONE; any in-flight conversion is dropped and produces no output.
- States: IDLE, CONV, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready at edge T: capture bcd_in, clear accumulator, set digit_idx = 0, go to CONV.
- CONV:
  - in_ready = 0.
  - Each cycle, take the digit at digit_idx.
  - If the digit is 9 or less: acc <= acc*10 + digit. Compute acc*10 as (acc<<3)+(acc<<1) in BIN_W+4 bits, then truncate to BIN_W. No overflow is possible when the BIN_W rule holds.
  - If the digit is greater than 9: set err = 1, set acc = 0, go to DONE immediately; remaining digits are skipped.
  - After the digit at index DIGITS-1 is processed, go to DONE.
- Latency, for a valid word accepted at edge T:
  - Digits are processed at edges T+1 through T+DIGITS.
  - out_valid is high from after edge T+DIGITS until the output handshake.
  - Valid word, default parameters: 4 conversion cycles; out_valid first seen in the cycle after edge T+4.
- Latency for an invalid word: if the first bad digit is at 1-based position k, out_valid is first seen after edge T+k.
- DONE:
  - out_valid = 1; bin_out and err hold stable while out_ready = 0, for any number of cycles.
  - On out_valid & out_ready: clear out_valid, return to IDLE. in_ready rises the following cycle.
  - There is no same-cycle output/input overlap, so the minimum throughput is one word per DIGITS+2 cycles.
- bin_out and err update only on entry to DONE. They keep the last result in IDLE and CONV, and are qualified only by out_valid.
- Leading zeros are legal. An all-zero word gives bin_out = 0, err = 0, with full DIGITS latency (no early exit).
- in_valid while busy: ignored, not captured (in_ready = 0).
- out_ready outside DONE: ignored.

Test Plan:
- Reset release, in_valid = 1 with bcd_in = 16'h1234 at edge T -> out_valid after edge T+4, bin_out = 14'd1234, err = 0, busy high T+1..handshake, digit_idx goes 0,1,2,3 during CONV.
- bcd_in = 16'h9999, then 16'h0000, back to back with out_ready held 1 -> results 9999/err 0, then 0/err 0. Second in_ready rises the cycle after the first output handshake.
- bcd_in = 16'h12A4 -> out_valid after edge T+3, err = 1, bin_out = 0. bcd_in = 16'hF000 -> out_valid after edge T+1, err = 1.
- Backpressure: bcd_in = 16'h0507, out_ready = 0 for 5 cycles after out_valid -> bin_out = 507 and err = 0 stay stable. in_valid pulses with 16'h1111 during this time are not captured. out_ready = 1 -> IDLE next cycle.
- Reset (reset = 0 for 1 cycle) during CONV at digit_idx = 2 -> next cycle IDLE, out_valid = 0, bin_out = 0, err = 0. A new word 16'h0042 then converts to 42.
- Reset during DONE with out_ready = 1 in the same cycle -> reset wins: no handshake is counted, outputs take reset values.
